mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 1, meaning the number of idle cycles between request capture and ack (legal range 0-15).
REQ-002 The block SHALL have parameter DEPTH, default 4096, meaning the number of 16-bit storage words (fixed to the 12-bit address space).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port addr, input, 12 bits: word address from the initiator.
REQ-006 The block SHALL have port data, inout, 16 bits: write data from the initiator, or read data driven by this block.
REQ-007 The block SHALL have port rdwr, input, 1 bit: 0 = read, 1 = write.
REQ-008 The block SHALL have port en, input, 1 bit: request valid, held high by the initiator until ack.
REQ-009 The block SHALL have port ack, output, 1 bit: transfer complete, one-cycle pulse.
REQ-010 The block SHALL have ports ld_en (input, 1 bit), ld_addr (input, 12 bits) and ld_data (input, 16 bits): the program-load write port.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have the states IDLE, WAIT, RESP and DONE.
REQ-013 In IDLE with en=1 and ld_en=0, the block SHALL:
- capture addr, rdwr and data (write data) into internal registers;
- load the wait counter with WAIT_CYCLES;
- go to WAIT, or go directly to RESP when WAIT_CYCLES=0.
REQ-014 In WAIT, the counter SHALL decrement each cycle; the block SHALL go to RESP on the cycle after the counter reaches 0.
REQ-015 If en falls while in WAIT, the block SHALL abort: return to IDLE next cycle, with no write and no ack.
REQ-016 In RESP, the block SHALL assert ack for exactly one cycle.
- Write: store the captured data at the captured address in this cycle.
- Read: drive mem[captured address] onto data.
- Next state is DONE.
REQ-017 In DONE, ack SHALL be 0; the block SHALL stay in DONE while en=1 and go to IDLE on the first cycle en=0.
REQ-018 data SHALL be driven only in RESP and DONE of a read transfer; data SHALL be high-Z at all other times, including during writes and reset.
REQ-019 Read data SHALL be stable from the ack rising edge until the return to IDLE.
REQ-020 Request latency from en rising to ack SHALL be WAIT_CYCLES+1 cycles (capture cycle plus wait cycles).
REQ-021 ld_en=1 in IDLE SHALL write ld_data to mem[ld_addr] that cycle.
REQ-022 ld_en SHALL take priority over en in IDLE; the pending request is captured on the first IDLE cycle with ld_en=0.
REQ-023 ld_en outside IDLE SHALL be ignored (no write).
REQ-024 Addresses SHALL map directly with no wrap logic: 12'hFFF is the last word.
REQ-025 A read of an address written in an earlier transfer SHALL return the written value; back-to-back transfers need one IDLE cycle between DONE and the next capture.

Reset
REQ-026 On rst=1 at a rising clk edge, the block SHALL:
- set the state to IDLE;
- set ack=0 and busy=0;
- clear the wait counter and captured registers;
- release data (high-Z).
REQ-027 Storage contents SHALL NOT be cleared by reset.
REQ-028 Reset mid-transfer SHALL abandon the transfer: no write and no ack.
REQ-029 rst SHALL take priority over ld_en and en.

Verification
REQ-030 Write then read, WAIT_CYCLES=1: write 16'h7A3C to 12'h010, then read 12'h010 -> ack exactly 2 cycles after each en rise; read returns 16'h7A3C; data is high-Z during the write.
REQ-031 WAIT_CYCLES=0, read 12'hFFF preloaded with 16'hBEEF via ld_en -> ack 1 cycle after en; data = 16'hBEEF until en falls.
REQ-032 en held high for 3 cycles after ack -> ack high exactly one cycle; busy stays 1 until the cycle after en falls; no second ack.
REQ-033 ld_en and en rise together in IDLE (ld_addr 12'h020 = 16'h1111, read of 12'h020) -> load happens first; read returns 16'h1111; ack is delayed by one cycle.
REQ-034 en dropped during WAIT (WAIT_CYCLES=3, write 16'hFFFF to 12'h005) -> no ack; mem[12'h005] unchanged; busy=0 next cycle.
REQ-035 rst asserted in RESP of a write of 16'h0F0F to 12'h100 -> ack=0, data high-Z, state IDLE; a word preloaded earlier at another address still reads back its value after reset.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/ack handshake and program-load port of mem_responder.
// The bidirectional data bus is a separate module-level net so tristate resolution happens there.
interface mem_responder_if;
    logic [11:0] addr;
    logic        rdwr;
    logic        en;
    logic        ack;
    logic        busy;
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [15:0] ld_data;

    modport master (
        output addr, rdwr, en, ld_en, ld_addr, ld_data,
        input  ack, busy
    );

    modport slave (
        input  addr, rdwr, en, ld_en, ld_addr, ld_data,
        output ack, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed 16-bit memory target with a programmable-latency request/ack handshake,
// a tristate data bus and a side port for preloading contents while idle.
module mem_responder #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned DEPTH       = 4096
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus,
    inout  wire  [15:0]     data
);

    typedef enum logic [1:0] {StIdle, StWait, StResp, StDone} state_e;

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [11:0] addr_q;
    logic        rdwr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        ack_q;
    logic        busy_q;
    logic        oe_q;

    logic [15:0] mem [DEPTH];

    // Control FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdwr_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                    oe_q   <= 1'b0;
                    if (bus.en && !bus.ld_en) begin
                        addr_q  <= bus.addr;
                        rdwr_q  <= bus.rdwr;
                        wdata_q <= bus.rdwr ? data : '0;
                        cnt_q   <= WaitLoad;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= StResp;
                            ack_q   <= 1'b1;
                            rdata_q <= mem[bus.addr];
                            oe_q    <= !bus.rdwr;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (!bus.en) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        // Counter hits zero on this edge, so the next cycle is the response.
                        if (cnt_q == 4'd1) begin
                            state_q <= StResp;
                            ack_q   <= 1'b1;
                            rdata_q <= mem[addr_q];
                            oe_q    <= !rdwr_q;
                        end
                    end
                end
                StResp: begin
                    state_q <= StDone;
                end
                StDone: begin
                    if (!bus.en) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        oe_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Storage is never reset; reset only suppresses a write in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StIdle && bus.ld_en) begin
                mem[bus.ld_addr] <= bus.ld_data;
            end else if (state_q == StResp && rdwr_q) begin
                mem[addr_q] <= wdata_q;
            end
        end
    end

    assign data     = oe_q ? rdata_q : 16'bz;
    assign bus.ack  = ack_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (wait 0, 1, 3) driven by directed and random transfers
// and checked against an associative-array memory model and latency arithmetic.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]       en_v;
    logic [2:0]       rdwr_v;
    logic [2:0]       ld_en_v;
    logic [2:0]       tb_oe;
    logic [2:0][11:0] addr_v;
    logic [2:0][11:0] ld_addr_v;
    logic [2:0][15:0] ld_data_v;
    logic [2:0][15:0] tb_dq;
    logic [2:0]       ack_v;
    logic [2:0]       busy_v;
    logic [2:0][15:0] dq_v;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        mem_responder_if bus ();
        wire [15:0] dq;
        assign dq          = tb_oe[g] ? tb_dq[g] : 16'bz;
        assign bus.addr    = addr_v[g];
        assign bus.rdwr    = rdwr_v[g];
        assign bus.en      = en_v[g];
        assign bus.ld_en   = ld_en_v[g];
        assign bus.ld_addr = ld_addr_v[g];
        assign bus.ld_data = ld_data_v[g];
        assign ack_v[g]    = bus.ack;
        assign busy_v[g]   = bus.busy;
        assign dq_v[g]     = dq;
        mem_responder #(.WAIT_CYCLES(W), .DEPTH(4096)) u_dut (
            .clk  (clk),
            .rst  (rst),
            .bus  (bus),
            .data (dq)
        );
    end

    int total = 0;
    int bad   = 0;
    logic [15:0] ref_mem [int];
    logic [11:0] known [$];

    function automatic int wc(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    function automatic int key(input int d, input logic [11:0] a);
        return d * 4096 + int'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Released bus: a bench-driven pattern must appear unperturbed.
    task automatic probe_z(input int d, input string tag);
        tb_dq[d] = 16'hC35A ^ 16'(d);
        tb_oe[d] = 1'b1;
        #1;
        chk(tag, dq_v[d], 16'hC35A ^ 16'(d));
        tb_oe[d] = 1'b0;
        #1;
    endtask

    task automatic load(input int d, input logic [11:0] a, input logic [15:0] v);
        ld_en_v[d]   = 1'b1;
        ld_addr_v[d] = a;
        ld_data_v[d] = v;
        step();
        ld_en_v[d]   = 1'b0;
        ref_mem[key(d, a)] = v;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [11:0] a, input logic [15:0] wv,
                        input int hold, input bit with_ld, input logic [15:0] ldv,
                        input bit stray, input string tag);
        int n;
        logic [15:0] exp;
        addr_v[d] = a;
        rdwr_v[d] = wr;
        en_v[d]   = 1'b1;
        tb_oe[d]  = wr;
        tb_dq[d]  = wv;
        if (with_ld) begin
            ld_en_v[d]   = 1'b1;
            ld_addr_v[d] = a;
            ld_data_v[d] = ldv;
        end
        n = 0;
        do begin
            step();
            n++;
            if (n == 1 && with_ld) begin
                ld_en_v[d] = 1'b0;
                ref_mem[key(d, a)] = ldv;
            end
        end while (!ack_v[d] && n < 40);
        chk({tag, "_lat"}, n, wc(d) + 1 + (with_ld ? 1 : 0));
        chk({tag, "_busy"}, busy_v[d], 1);
        if (wr) begin
            chk({tag, "_wz"}, dq_v[d], wv);
            ref_mem[key(d, a)] = wv;
            exp = wv;
        end else begin
            exp = ref_mem.exists(key(d, a)) ? ref_mem[key(d, a)] : 16'hxxxx;
            chk({tag, "_rd"}, dq_v[d], exp);
        end
        // A load attempted while busy must be dropped.
        if (stray) begin
            ld_en_v[d]   = 1'b1;
            ld_addr_v[d] = a;
            ld_data_v[d] = ~exp;
        end
        for (int k = 0; k < hold; k++) begin
            step();
            ld_en_v[d] = 1'b0;
            chk({tag, "_ack1"}, ack_v[d], 0);
            chk({tag, "_hbusy"}, busy_v[d], 1);
            if (!wr) chk({tag, "_hold"}, dq_v[d], exp);
        end
        en_v[d]    = 1'b0;
        tb_oe[d]   = 1'b0;
        ld_en_v[d] = 1'b0;
        step();
        chk({tag, "_idle_busy"}, busy_v[d], 0);
        chk({tag, "_idle_ack"}, ack_v[d], 0);
        probe_z(d, {tag, "_z"});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned op;
        logic [11:0] ra;
        logic [15:0] rv;
        int          rh;
        bit          rl;
        bit          rs;

        rst       = 1'b1;
        en_v      = '0;
        rdwr_v    = '0;
        ld_en_v   = '0;
        tb_oe     = '0;
        addr_v    = '0;
        ld_addr_v = '0;
        ld_data_v = '0;
        tb_dq     = '0;
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            chk("rst_busy", busy_v[d], 0);
            chk("rst_ack", ack_v[d], 0);
            probe_z(d, "rst_z");
        end
        rst = 1'b0;
        step();

        // Write then read at wait 1, with a stray load during the write.
        xfer(1, 1'b1, 12'h010, 16'h7A3C, 1, 1'b0, 16'h0, 1'b1, "wr010");
        xfer(1, 1'b0, 12'h010, 16'h0,    1, 1'b0, 16'h0, 1'b0, "rd010");

        // Zero wait, top address preloaded.
        load(0, 12'hFFF, 16'hBEEF);
        xfer(0, 1'b0, 12'hFFF, 16'h0, 2, 1'b0, 16'h0, 1'b0, "rdfff");

        // en held three cycles past ack.
        xfer(1, 1'b0, 12'h010, 16'h0, 3, 1'b0, 16'h0, 1'b0, "hold3");

        // Load and request together: load wins, request one cycle later.
        xfer(1, 1'b0, 12'h020, 16'h0, 1, 1'b1, 16'h1111, 1'b0, "ldpri");

        // Abort during wait at wait 3.
        load(2, 12'h005, 16'h2468);
        addr_v[2] = 12'h005;
        rdwr_v[2] = 1'b1;
        en_v[2]   = 1'b1;
        tb_oe[2]  = 1'b1;
        tb_dq[2]  = 16'hFFFF;
        step();
        chk("abort_ack_a", ack_v[2], 0);
        chk("abort_busy_a", busy_v[2], 1);
        step();
        chk("abort_ack_b", ack_v[2], 0);
        en_v[2]  = 1'b0;
        tb_oe[2] = 1'b0;
        step();
        chk("abort_busy", busy_v[2], 0);
        chk("abort_ack_c", ack_v[2], 0);
        step();
        chk("abort_ack_d", ack_v[2], 0);
        xfer(2, 1'b0, 12'h005, 16'h0, 1, 1'b0, 16'h0, 1'b0, "abort_rd");

        // Reset during the response cycle of a write.
        load(1, 12'h0AA, 16'h5AA5);
        load(1, 12'h100, 16'h1357);
        addr_v[1] = 12'h100;
        rdwr_v[1] = 1'b1;
        en_v[1]   = 1'b1;
        tb_oe[1]  = 1'b1;
        tb_dq[1]  = 16'h0F0F;
        step();
        step();
        chk("rstmid_ack_pre", ack_v[1], 1);
        rst = 1'b1;
        step();
        chk("rstmid_ack", ack_v[1], 0);
        chk("rstmid_busy", busy_v[1], 0);
        en_v[1]  = 1'b0;
        tb_oe[1] = 1'b0;
        probe_z(1, "rstmid_z");
        rst = 1'b0;
        step();
        xfer(1, 1'b0, 12'h100, 16'h0, 1, 1'b0, 16'h0, 1'b0, "rstmid_rd100");
        xfer(1, 1'b0, 12'h0AA, 16'h0, 1, 1'b0, 16'h0, 1'b0, "rstmid_rd0aa");

        // Random mix of loads, writes and reads on each responder.
        for (int d = 0; d < 3; d++) begin
            known.delete();
            for (int i = 0; i < 25; i++) begin
                op = $urandom_range(0, 9);
                ra = 12'($urandom);
                rv = 16'($urandom);
                rh = $urandom_range(1, 3);
                rl = ($urandom_range(0, 3) == 0);
                rs = ($urandom_range(0, 3) == 0);
                if (known.size() == 0) op = 3;
                if (op < 2) begin
                    load(d, ra, rv);
                    known.push_back(ra);
                end else if (op < 6) begin
                    xfer(d, 1'b1, ra, rv, rh, 1'b0, 16'h0, rs, "rnd_wr");
                    known.push_back(ra);
                end else begin
                    ra = known[$urandom_range(0, known.size() - 1)];
                    xfer(d, 1'b0, ra, 16'h0, rh, rl, rv, rs, "rnd_rd");
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
